// File: rtl/ahb_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_pkg
// Shared types for the AHB-Lite SRAM slave: HTRANS encoding, HRESP values,
// the data-phase state machine encoding and the wait-counter preload helper.
// ---------------------------------------------------------------------------
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_t;

    // Number of WAIT cycles in front of LAST. Reads need at least one so the
    // SRAM strobe lands a cycle before the data is returned.
    function automatic logic [2:0] first_wait_count(input logic is_write,
                                                    input logic [2:0] wait_states);
        logic [2:0] cnt;
        if (is_write) begin
            cnt = wait_states;
        end else if (wait_states == 3'd0) begin
            cnt = 3'd1;
        end else begin
            cnt = wait_states;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB-Lite slave-side bus bundle.
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY,
//                   observes HRDATA/HREADYOUT/HRESP.
//   slave modport : the mirror image.
// HREADY is the bus-level ready produced by the interconnect.
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if
    import ahb_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    htrans_t           HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lane_decode.sv
// ---------------------------------------------------------------------------
// ahb_lane_decode
// Maps an AHB transfer size and the low address bits to byte-lane enables.
//   hsize    : log2 of transfer size in bytes
//   low      : byte offset inside a data word
//   mask     : 1 per byte lane touched by the transfer
//   misalign : address not a multiple of the transfer size
// Oversized transfers are not flagged here; the caller knows its bus width.
// ---------------------------------------------------------------------------
module ahb_lane_decode #(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int LW     = $clog2(BYTES)
) (
    input  logic [2:0]       hsize,
    input  logic [LW-1:0]    low,
    output logic [BYTES-1:0] mask,
    output logic             misalign
);

    logic [8:0] nbytes_s;
    logic [8:0] low_s;
    logic [8:0] end_s;

    // Lanes [low, low + size) are enabled; misalignment is any low bit set
    // below the transfer size.
    always_comb begin
        nbytes_s = 9'd1 << hsize;
        low_s    = 9'(low);
        end_s    = low_s + nbytes_s;
        mask     = '0;
        for (int i = 0; i < BYTES; i++) begin
            if ((9'(i) >= low_s) && (9'(i) < end_s)) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        misalign = ((low_s & (nbytes_s - 9'd1)) != 9'd0);
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite slave in front of a single-port synchronous SRAM with active-low
// strobes and one-cycle read latency.
//   HCLK, HRESET : clock and asynchronous active-high reset
//   bus          : AHB-Lite slave port (ahb_sram_slave_if.slave)
//   sram_cen/wen : chip / write enable, active-low
//   sram_ben     : byte-write enables, active-low
//   sram_addr    : word-aligned byte offset from BASE_ADDR
//   sram_din     : write data (HWDATA during the write LAST cycle)
//   sram_dout    : read data, valid the cycle after a read strobe
// Writes take WAIT_STATES+1 data-phase cycles and strobe in LAST. Reads take
// max(WAIT_STATES,1)+1 cycles: strobe in the final WAIT cycle, return data
// in LAST. Faulting transfers get a two-cycle ERROR with no SRAM access.
// ---------------------------------------------------------------------------
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter longint unsigned   MEM_BYTES   = 64'd16777216,
    parameter int                WAIT_STATES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_sram_slave_if.slave       bus,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [DATA_W/8-1:0]   sram_ben,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_din,
    input  logic [DATA_W-1:0]     sram_dout
);

    localparam int              BYTES     = DATA_W / 8;
    localparam int              LW        = $clog2(BYTES);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [2:0]      WS        = 3'(WAIT_STATES);

    ahb_slv_state_t    state_r, state_s;
    logic [2:0]        cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              write_r, write_s;
    logic [BYTES-1:0]  mask_r, mask_s;

    logic [ADDR_W-1:0] offset_s;
    logic [BYTES-1:0]  mask_dec_s;
    logic              misalign_s;
    logic              fault_s;
    logic              active_s;
    logic [2:0]        load_cnt_s;

    ahb_lane_decode #(.DATA_W(DATA_W)) u_lane_decode (
        .hsize    (bus.HSIZE),
        .low      (offset_s[LW-1:0]),
        .mask     (mask_dec_s),
        .misalign (misalign_s)
    );

    // Address-phase decode: unsigned offset (below BASE_ADDR wraps high and
    // faults), range/size/alignment checks, and the transfer-valid qualifier.
    always_comb begin
        offset_s   = bus.HADDR - BASE_ADDR;
        fault_s    = ({1'b0, offset_s} >= MEM_LIMIT) ||
                     (bus.HSIZE > 3'(LW)) ||
                     misalign_s;
        active_s   = bus.HSEL && bus.HREADY &&
                     ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
        load_cnt_s = first_wait_count(bus.HWRITE, WS);
    end

    // Next-state logic; new transfers are only taken while HREADYOUT is high.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        write_s = write_r;
        mask_s  = mask_r;
        case (state_r)
            ST_WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_s = ST_LAST;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_ERR1: begin
                state_s = ST_ERR2;
            end
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (active_s) begin
                    addr_s  = {offset_s[ADDR_W-1:LW], {LW{1'b0}}};
                    write_s = bus.HWRITE;
                    mask_s  = mask_dec_s;
                    if (fault_s) begin
                        state_s = ST_ERR1;
                        cnt_s   = 3'd0;
                    end else if (load_cnt_s == 3'd0) begin
                        state_s = ST_LAST;
                        cnt_s   = 3'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = load_cnt_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 3'd0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State, wait counter and captured address-phase attributes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            addr_r  <= '0;
            write_r <= 1'b0;
            mask_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            write_r <= write_s;
            mask_r  <= mask_s;
        end
    end

    // Bus response and SRAM strobes decoded from registered state only
    // (plus HWDATA for write data), so HADDR never reaches the SRAM pins.
    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        bus.HRDATA    = '0;
        sram_cen      = 1'b1;
        sram_wen      = 1'b1;
        sram_ben      = '1;
        sram_din      = '0;
        sram_addr     = addr_r;
        case (state_r)
            ST_WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (!write_r && (cnt_r == 3'd1)) begin
                    sram_cen = 1'b0;
                    sram_ben = '0;
                end else begin
                    sram_cen = 1'b1;
                end
            end
            ST_LAST: begin
                if (write_r) begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    sram_ben = ~mask_r;
                    sram_din = bus.HWDATA;
                end else begin
                    bus.HRDATA = sram_dout;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                bus.HRESP = HRESP_ERROR;
            end
            default: begin
                bus.HREADYOUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: dut_a has two wait states, dut_b none. Each has its own
// behavioural SRAM (64 words, indexed by address bits 7:2).
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_clr;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    htrans_t     htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          cur;
    int          checks = 0;
    int          errors = 0;

    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

    assign if_a.HSEL   = hsel_a;
    assign if_a.HADDR  = haddr;
    assign if_a.HTRANS = htrans;
    assign if_a.HWRITE = hwrite;
    assign if_a.HSIZE  = hsize;
    assign if_a.HWDATA = hwdata;
    assign if_a.HREADY = if_a.HREADYOUT;
    assign if_b.HSEL   = hsel_b;
    assign if_b.HADDR  = haddr;
    assign if_b.HTRANS = htrans;
    assign if_b.HWRITE = hwrite;
    assign if_b.HSIZE  = hsize;
    assign if_b.HWDATA = hwdata;
    assign if_b.HREADY = if_b.HREADYOUT;

    logic        cen_a, wen_a, cen_b, wen_b;
    logic [3:0]  ben_a, ben_b;
    logic [31:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0),
                     .MEM_BYTES(64'd16777216), .WAIT_STATES(2)) dut_a (
        .HCLK(clk), .HRESET(rst), .bus(if_a),
        .sram_cen(cen_a), .sram_wen(wen_a), .sram_ben(ben_a),
        .sram_addr(addr_a), .sram_din(din_a), .sram_dout(dout_a));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0),
                     .MEM_BYTES(64'd16777216), .WAIT_STATES(0)) dut_b (
        .HCLK(clk), .HRESET(rst), .bus(if_b),
        .sram_cen(cen_b), .sram_wen(wen_b), .sram_ben(ben_b),
        .sram_addr(addr_b), .sram_din(din_b), .sram_dout(dout_b));

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int          scnt_a = 0, scnt_b = 0;
    logic [3:0]  sben_a, sben_b;
    logic [31:0] saddr_a, saddr_b;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'h0;
        end else if (!cen_a) begin
            scnt_a  <= scnt_a + 1;
            sben_a  <= ben_a;
            saddr_a <= addr_a;
            if (!wen_a) begin
                for (int k = 0; k < 4; k++)
                    if (!ben_a[k]) mem_a[addr_a[7:2]][k*8 +: 8] <= din_a[k*8 +: 8];
            end else begin
                dout_a <= mem_a[addr_a[7:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int j = 0; j < 64; j++) mem_b[j] <= 32'h0;
        end else if (!cen_b) begin
            scnt_b  <= scnt_b + 1;
            sben_b  <= ben_b;
            saddr_b <= addr_b;
            if (!wen_b) begin
                for (int m = 0; m < 4; m++)
                    if (!ben_b[m]) mem_b[addr_b[7:2]][m*8 +: 8] <= din_b[m*8 +: 8];
            end else begin
                dout_b <= mem_b[addr_b[7:2]];
            end
        end
    end

    // Observation mux for the DUT currently under test.
    logic        rdy_o, resp_o, cen_o, wen_o;
    logic [31:0] rdata_o, saddr_o, din_o, last_addr_o;
    logic [3:0]  ben_o, last_ben_o;
    int          scnt_o;
    always_comb begin
        if (cur == 0) begin
            rdy_o = if_a.HREADYOUT; resp_o = if_a.HRESP; rdata_o = if_a.HRDATA;
            cen_o = cen_a; wen_o = wen_a; ben_o = ben_a; saddr_o = addr_a; din_o = din_a;
            scnt_o = scnt_a; last_ben_o = sben_a; last_addr_o = saddr_a;
        end else begin
            rdy_o = if_b.HREADYOUT; resp_o = if_b.HRESP; rdata_o = if_b.HRDATA;
            cen_o = cen_b; wen_o = wen_b; ben_o = ben_b; saddr_o = addr_b; din_o = din_b;
            scnt_o = scnt_b; last_ben_o = sben_b; last_addr_o = saddr_b;
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_strobe;
        logic [3:0]  exp_ben;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                                input int lat, input logic strobe, input logic [3:0] ben);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.exp_err = err;
        v.exp_rdata = rdata; v.exp_lat = lat; v.exp_strobe = strobe; v.exp_ben = ben;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One isolated transfer; returns data-phase length, strobe cycle, response.
    task automatic xfer(input vec_t v, output int lat, output int scyc,
                        output logic resp, output logic [31:0] rdata);
        @(negedge clk);
        if (cur == 0) hsel_a = 1'b1; else hsel_b = 1'b1;
        htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.wr; hsize = v.size;
        @(negedge clk);
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = HTRANS_IDLE; hwdata = v.wdata;
        #1;
        lat = 1; scyc = 0;
        while (!rdy_o && lat < 16) begin
            if (!cen_o) scyc = lat;
            @(negedge clk);
            #1;
            lat++;
        end
        if (!cen_o) scyc = lat;
        resp = resp_o; rdata = rdata_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [14];
        int          lat, scyc, c0;
        logic        resp;
        logic [31:0] rdata;

        vecs[0]  = mk(1'b1, 3'd2, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0,        3, 1'b1, 4'b0000);
        vecs[1]  = mk(1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b1, 4'b0000);
        vecs[2]  = mk(1'b1, 3'd0, 32'h13,        32'hAB000000, 1'b0, 32'h0,        3, 1'b1, 4'b0111);
        vecs[3]  = mk(1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'hABADBEEF, 3, 1'b1, 4'b0000);
        vecs[4]  = mk(1'b1, 3'd1, 32'h11,        32'h00CDCD00, 1'b1, 32'h0,        2, 1'b0, 4'b1111);
        vecs[5]  = mk(1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'hABADBEEF, 3, 1'b1, 4'b0000);
        vecs[6]  = mk(1'b0, 3'd2, 32'h01000000,  32'h0,        1'b1, 32'h0,        2, 1'b0, 4'b1111);
        vecs[7]  = mk(1'b0, 3'd2, 32'h00FFFFFC,  32'h0,        1'b0, 32'h0,        3, 1'b1, 4'b0000);
        vecs[8]  = mk(1'b1, 3'd1, 32'h12,        32'h12340000, 1'b0, 32'h0,        3, 1'b1, 4'b0011);
        vecs[9]  = mk(1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'h1234BEEF, 3, 1'b1, 4'b0000);
        vecs[10] = mk(1'b0, 3'd2, 32'h12,        32'h0,        1'b1, 32'h0,        2, 1'b0, 4'b1111);
        vecs[11] = mk(1'b0, 3'd3, 32'h10,        32'h0,        1'b1, 32'h0,        2, 1'b0, 4'b1111);
        vecs[12] = mk(1'b1, 3'd0, 32'h10,        32'h0000005A, 1'b0, 32'h0,        3, 1'b1, 4'b1110);
        vecs[13] = mk(1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'h1234BE5A, 3, 1'b1, 4'b0000);

        cur = 0; rst = 1'b1; mem_clr = 1'b1;
        hsel_a = 1'b0; hsel_b = 1'b0; haddr = 32'h0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hreadyout", 32'(rdy_o), 32'h1);
        chk("rst_hresp", 32'(resp_o), 32'h0);
        chk("rst_hrdata", rdata_o, 32'h0);
        chk("rst_cen", 32'(cen_o), 32'h1);
        chk("rst_wen", 32'(wen_o), 32'h1);
        chk("rst_ben", 32'(ben_o), 32'hF);
        chk("rst_addr", saddr_o, 32'h0);
        chk("rst_din", din_o, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;

        // Table: isolated transfers on the two-wait-state slave.
        for (int i = 0; i < 14; i++) begin
            c0 = scnt_o;
            xfer(vecs[i], lat, scyc, resp, rdata);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_hresp", i), 32'(resp), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_hrdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_strobes", i), 32'(scnt_o - c0), 32'(vecs[i].exp_strobe));
            if (vecs[i].exp_strobe) begin
                chk($sformatf("v%0d_ben", i), 32'(last_ben_o), 32'(vecs[i].exp_ben));
                chk($sformatf("v%0d_addr", i), last_addr_o, vecs[i].addr & 32'hFFFFFFFC);
                chk($sformatf("v%0d_strobe_cycle", i), 32'(scyc),
                    32'(vecs[i].wr ? vecs[i].exp_lat : vecs[i].exp_lat - 1));
            end
        end

        // Reset during a write WAIT cycle: immediate reset outputs, no write.
        c0 = scnt_o;
        @(negedge clk);
        hsel_a = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        hsel_a = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
        #1;
        chk("rstw_wait_hreadyout", 32'(rdy_o), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("rstw_async_hreadyout", 32'(rdy_o), 32'h1);
        chk("rstw_async_cen", 32'(cen_o), 32'h1);
        chk("rstw_async_addr", saddr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hsel_a = 1'b1; htrans = HTRANS_IDLE;
        @(negedge clk);
        #1;
        chk("idle_hreadyout", 32'(rdy_o), 32'h1);
        chk("idle_hresp", 32'(resp_o), 32'h0);
        hsel_a = 1'b0;
        chk("rstw_no_strobe", 32'(scnt_o - c0), 32'h0);
        xfer(mk(1'b0, 3'd2, 32'h14, 32'h0, 1'b0, 32'h0, 3, 1'b1, 4'b0000), lat, scyc, resp, rdata);
        chk("rstw_readback", rdata, 32'h0);

        // Zero-wait slave: back-to-back W@0x20, R@0x20, W@0x24.
        cur = 1;
        @(negedge clk);
        hsel_b = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        chk("s_w1_hreadyout", 32'(rdy_o), 32'h1);
        hwdata = 32'h11223344; haddr = 32'h20; hwrite = 1'b0;
        #1;
        chk("s_w1_cen", 32'(cen_o), 32'h0);
        chk("s_w1_wen", 32'(wen_o), 32'h0);
        chk("s_w1_din", din_o, 32'h11223344);
        chk("s_w1_addr", saddr_o, 32'h20);
        @(negedge clk);
        #1;
        chk("s_r_wait_hreadyout", 32'(rdy_o), 32'h0);
        chk("s_r_wait_cen", 32'(cen_o), 32'h0);
        chk("s_r_wait_wen", 32'(wen_o), 32'h1);
        haddr = 32'h24; hwrite = 1'b1;
        @(negedge clk);
        #1;
        chk("s_r_last_hreadyout", 32'(rdy_o), 32'h1);
        chk("s_r_last_hrdata", rdata_o, 32'h11223344);
        @(negedge clk);
        hsel_b = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h55667788;
        #1;
        chk("s_w2_hreadyout", 32'(rdy_o), 32'h1);
        chk("s_w2_cen", 32'(cen_o), 32'h0);
        chk("s_w2_addr", saddr_o, 32'h24);
        @(posedge clk);
        #1;
        xfer(mk(1'b0, 3'd2, 32'h24, 32'h0, 1'b0, 32'h0, 2, 1'b1, 4'b0000), lat, scyc, resp, rdata);
        chk("s_r2_latency", 32'(lat), 32'd2);
        chk("s_r2_hrdata", rdata, 32'h55667788);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
